// File: rtl/mem_bist_pkg.sv
// mem_bist shared definitions: FSM encoding and address/counter width
// helpers that other memory masters can reuse.
`ifndef MEM_BIST_PKG_SV
`define MEM_BIST_PKG_SV

`define MEM_BIST_ADDR_SIZE(n) $clog2(n)
`define MEM_BIST_CNT_W(n) ($clog2(n) + 2)

package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_RD0  = 3'd2,
        ST_WR1  = 3'd3,
        ST_RD1  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

endpackage

`endif

// File: rtl/mem_bist_pattern.sv
// mem_bist pattern generator: word = seed ^ addr, optionally inverted.
// The address is zero-extended or truncated to the data width.
module mem_bist_pattern #(
    parameter int DATA_W    = 10,
    parameter int ADDR_SIZE = 3
) (
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    seed,
    input  logic                 invert,
    output logic [DATA_W-1:0]    word
);

    logic [DATA_W-1:0] addr_ext;

    if (DATA_W >= ADDR_SIZE) begin : g_ext
        assign addr_ext = DATA_W'(addr);
    end else begin : g_trunc
        assign addr_ext = addr[DATA_W-1:0];
    end

    assign word = invert ? ~(seed ^ addr_ext) : (seed ^ addr_ext);

endmodule

// File: rtl/mem_bist.sv
// mem_bist top: two-pass write/read-compare walk over one memory,
// reporting pass/fail, first failing address and a saturating error count.
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int MEM_SIZE = 6,
    parameter int DATA_W   = 10,
    localparam int ADDR_SIZE = `MEM_BIST_ADDR_SIZE(MEM_SIZE),
    localparam int CNT_W     = `MEM_BIST_CNT_W(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_SIZE-1:0] fail_addr,
    output logic [CNT_W-1:0]     err_count,
    output logic                 write_flag,
    output logic [DATA_W-1:0]    data_in,
    output logic [ADDR_SIZE-1:0] addr_w,
    output logic                 read_flag,
    output logic [ADDR_SIZE-1:0] addr_r,
    input  logic [DATA_W-1:0]    data_out
);

    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_SIZE - 1);

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
    logic                 drain_q, drain_d;
    logic [DATA_W-1:0]    seed_q, seed_d;
    logic [CNT_W-1:0]     err_q, err_d;
    logic [ADDR_SIZE-1:0] fail_q, fail_d;
    logic                 pass_q, pass_d;
    logic                 pend_q, pend_d;
    logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]    exp_q, exp_d;

    logic              wr_en;
    logic              rd_en;
    logic              miscmp;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] exp_word;

    mem_bist_pattern #(
        .DATA_W    (DATA_W),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_wr_pat (
        .addr   (cnt_q),
        .seed   (seed_q),
        .invert (state_q == ST_WR1),
        .word   (wr_word)
    );

    mem_bist_pattern #(
        .DATA_W    (DATA_W),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_exp_pat (
        .addr   (cnt_q),
        .seed   (seed_q),
        .invert (state_q == ST_RD1),
        .word   (exp_word)
    );

    // Next-state, phase sequencing and miscompare bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        seed_d      = seed_q;
        err_d       = err_q;
        fail_d      = fail_q;
        pass_d      = pass_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        pass        = pass_q;
        miscmp      = pend_q && (data_out != exp_q);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WR0;
                    seed_d  = seed;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    drain_d = 1'b0;
                end
            end
            ST_WR0, ST_WR1: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == ST_WR0) ? ST_RD0 : ST_RD1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RD0, ST_RD1: begin
                busy = 1'b1;
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = (state_q == ST_RD0) ? ST_WR1 : ST_FIN;
                end else begin
                    rd_en = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        drain_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                pass    = (err_q == '0);
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (miscmp) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) fail_d = pend_addr_q;
        end
        pend_d      = rd_en;
        pend_addr_d = cnt_q;
        exp_d       = exp_word;
    end

    // State, counters, results and the read-compare pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            seed_q      <= '0;
            err_q       <= '0;
            fail_q      <= '0;
            pass_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            seed_q      <= seed_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
            pass_q      <= pass_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            exp_q       <= exp_d;
        end
    end

    assign write_flag = wr_en;
    assign data_in    = wr_en ? wr_word : '0;
    assign addr_w     = wr_en ? cnt_q : '0;
    assign read_flag  = rd_en;
    assign addr_r     = rd_en ? cnt_q : '0;
    assign err_count  = err_q;
    assign fail_addr  = fail_q;

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: directed bench with a 6x10 memory model and fault
// injection on the read data path.
module tb_mem_bist;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] seed;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_addr;
    logic [4:0] err_count;
    logic       write_flag;
    logic [9:0] data_in;
    logic [2:0] addr_w;
    logic       read_flag;
    logic [2:0] addr_r;
    logic [9:0] data_out;

    int n_assert = 0;
    int n_fail   = 0;
    int viol     = 0;

    logic [9:0] mem [0:5];
    logic [9:0] rdata;
    logic [2:0] raddr_q;
    logic [1:0] fault;

    mem_bist dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .err_count  (err_count),
        .write_flag (write_flag),
        .data_in    (data_in),
        .addr_w     (addr_w),
        .read_flag  (read_flag),
        .addr_r     (addr_r),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: posedge write, 1-cycle synchronous read
    always @(posedge clk) begin
        if (write_flag && addr_w < 3'd6) mem[addr_w] <= data_in;
        if (read_flag && addr_r < 3'd6) begin
            rdata   <= mem[addr_r];
            raddr_q <= addr_r;
        end
    end

    // Fault injection on read data
    always_comb begin
        data_out = rdata;
        if (fault == 2'd1 && raddr_q == 3'd3) data_out[0] = 1'b1;
        else if (fault == 2'd2) data_out = '0;
    end

    // Bus rule monitor
    always @(negedge clk) begin
        if (addr_w > 3'd5 || addr_r > 3'd5 || (write_flag && read_flag))
            viol++;
    end

    task automatic run_bist(
        input  logic [9:0] s,
        input  int         restart_at,
        output int         done_cyc,
        output int         done_cnt,
        output logic [9:0] wd0,
        output logic [9:0] wd1,
        output logic       busy1,
        output logic       busy26
    );
        int nwr2;
        done_cyc = -1;
        done_cnt = 0;
        wd0 = '0;
        wd1 = '0;
        busy1 = 1'b0;
        busy26 = 1'b0;
        nwr2 = 0;
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) seed = ~s;
            start = (k == restart_at);
            if (write_flag && addr_w == 3'd2) begin
                if (nwr2 == 0) wd0 = data_in;
                else wd1 = data_in;
                nwr2++;
            end
            if (k == 1) busy1 = busy;
            if (k == 26) busy26 = busy;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        logic [28:0] o;
        #1;
        o = {write_flag, read_flag, busy, done, pass, data_in,
             addr_w, addr_r, fail_addr, err_count};
        n_assert++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0 0",
                     busy, done);
        end
    endtask

    task automatic test_good_run;
        int dc, dn;
        logic [9:0] w0, w1;
        logic b1, b26;
        fault = 2'd0;
        run_bist(10'h123, 0, dc, dn, w0, w1, b1, b26);
        n_assert++;
        if (dc !== 27) begin
            n_fail++;
            $display("FAIL good_done_cycle: got %0d want 27", dc);
        end
        n_assert++;
        if (dn !== 1) begin
            n_fail++;
            $display("FAIL good_done_count: got %0d want 1", dn);
        end
        n_assert++;
        if (w0 !== 10'h121) begin
            n_fail++;
            $display("FAIL good_wr0_addr2: got %h want 121", w0);
        end
        n_assert++;
        if (w1 !== 10'h2DE) begin
            n_fail++;
            $display("FAIL good_wr1_addr2: got %h want 2de", w1);
        end
        n_assert++;
        if (b1 !== 1'b1 || b26 !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_busy: got %b%b%b want 110", b1, b26, busy);
        end
        n_assert++;
        if (pass !== 1'b1 || err_count !== 5'd0 || fail_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL good_result: pass=%b err=%0d fa=%0d want 1 0 0",
                     pass, err_count, fail_addr);
        end
    endtask

    task automatic test_stuck_bit;
        int dc, dn;
        logic [9:0] w0, w1;
        logic b1, b26;
        fault = 2'd1;
        run_bist(10'h123, 0, dc, dn, w0, w1, b1, b26);
        n_assert++;
        if (pass !== 1'b0 || err_count !== 5'd1 || fail_addr !== 3'd3) begin
            n_fail++;
            $display("FAIL stuck1_result: pass=%b err=%0d fa=%0d want 0 1 3",
                     pass, err_count, fail_addr);
        end
        fault = 2'd2;
        run_bist(10'h000, 0, dc, dn, w0, w1, b1, b26);
        n_assert++;
        if (pass !== 1'b0 || err_count !== 5'd11 || fail_addr !== 3'd1) begin
            n_fail++;
            $display("FAIL stuck0_result: pass=%b err=%0d fa=%0d want 0 11 1",
                     pass, err_count, fail_addr);
        end
        n_assert++;
        if (dc !== 27) begin
            n_fail++;
            $display("FAIL stuck0_done_cycle: got %0d want 27", dc);
        end
        fault = 2'd0;
    endtask

    task automatic test_back_to_back;
        int dc, dn;
        logic [9:0] w0, w1;
        logic b1, b26;
        fault = 2'd1;
        run_bist(10'h123, 10, dc, dn, w0, w1, b1, b26);
        n_assert++;
        if (dc !== 27 || dn !== 1) begin
            n_fail++;
            $display("FAIL restart_ignored: done_at=%0d n=%0d want 27 1",
                     dc, dn);
        end
        n_assert++;
        if (err_count !== 5'd1 || fail_addr !== 3'd3) begin
            n_fail++;
            $display("FAIL restart_result: err=%0d fa=%0d want 1 3",
                     err_count, fail_addr);
        end
        fault = 2'd0;
        run_bist(10'h2A5, 0, dc, dn, w0, w1, b1, b26);
        n_assert++;
        if (pass !== 1'b1 || err_count !== 5'd0 || fail_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL rerun_clean: pass=%b err=%0d fa=%0d want 1 0 0",
                     pass, err_count, fail_addr);
        end
        n_assert++;
        if (w0 !== 10'h2A7 || w1 !== 10'h158) begin
            n_fail++;
            $display("FAIL rerun_wr_data: got %h %h want 2a7 158", w0, w1);
        end
    endtask

    task automatic test_reset_mid_run;
        int dc, dn;
        logic [9:0] w0, w1;
        logic b1, b26;
        logic [28:0] o;
        logic rd_seen;
        fault = 2'd2;
        @(negedge clk);
        seed  = 10'h000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rd_seen = read_flag;
        rst = 1'b1;
        #1;
        o = {write_flag, read_flag, busy, done, pass, data_in,
             addr_w, addr_r, fail_addr, err_count};
        n_assert++;
        if (rd_seen !== 1'b1 || o !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_rd0: rd=%b outs=%h want 1 0",
                     rd_seen, o);
        end
        @(negedge clk);
        rst = 1'b0;
        fault = 2'd0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (busy !== 1'b0 || write_flag !== 1'b0 || read_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b wf=%b rf=%b want 0 0 0",
                     busy, write_flag, read_flag);
        end
        run_bist(10'h3C0, 0, dc, dn, w0, w1, b1, b26);
        n_assert++;
        if (dc !== 27 || pass !== 1'b1 || err_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_rerun: done_at=%0d pass=%b err=%0d want 27 1 0",
                     dc, pass, err_count);
        end
    endtask

    task automatic test_bus_rules;
        n_assert++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL bus_rules: got %0d violations want 0", viol);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        seed  = '0;
        fault = 2'd0;
        test_reset();
        test_good_run();
        test_stuck_bit();
        test_back_to_back();
        test_reset_mid_run();
        test_bus_rules();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
